can_rx_frame_packer: RTL and testbench
======================================

# can_rx_frame_packer

Receive-side frame assembler between the CAN bit decoder and the Rx FIFO. It consumes the destuffed bit stream and parses standard and extended data/remote frames. It checks CRC-15 and packs each good frame into one 128-bit word written into the Rx FIFO (DATA_WIDTH = 128). Bad, aborted or overrun frames are discarded and flagged.

## Interface
- DATA_WIDTH, 128, FIFO word width; fixed at 128, the frame layout requires it.
- TS_WIDTH, 16, timestamp counter width; used only with CAN_RX_TIMESTAMP_EN.

Ports:
- i_sys_clk  in  1  system clock; sole clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_sof  in  1  one-cycle strobe coinciding with the SOF bit's i_bit_valid.
- i_bit_valid  in  1  qualifies i_bit; at most one per cycle.
- i_bit  in  1  destuffed bus bit (0 = dominant).
- i_abort  in  1  error frame / bus error; kills the frame in progress.
- i_fifo_full  in  1  Rx FIFO full flag.
- o_fifo_w_data  out  128  packed frame word.
- o_fifo_wr_en  out  1  one-cycle write strobe to Rx FIFO.
- o_crc_ok  out  1  one-cycle pulse: CRC matched (drives ACK slot).
- o_crc_err  out  1  one-cycle pulse: CRC mismatch.
- o_overrun  out  1  one-cycle pulse: good frame dropped, FIFO full.
- o_busy  out  1  high from SOF until frame end or abort.

## Operation
- Word layout:
  - [63:0] data, byte0 at [63:56]; unused bytes 0.
  - [67:64] raw DLC.
  - [68] RTR.
  - [69] IDE.
  - [98:70] ID. Standard: ID[10:0] in [98:88], [87:70] = 0. Extended: IDA[10:0] in [98:88], IDB[17:0] in [87:70].
  - [127:99] reserved 0, except timestamp (see Configuration).
- FSM states: IDLE, ID_A (11 bits), SRR_RTR, IDE, ID_B (18), RTR_X, R1, R0, DLC (4), DATA, CRC (15), DONE.
- IDLE→ID_A on i_sof & i_bit_valid.
- Standard path: ID_A→SRR_RTR (captured as RTR)→IDE=0→R0→DLC.
- Extended path: ID_A→SRR_RTR→IDE=1→ID_B→RTR_X→R1→R0→DLC.
- Reserved bits are ignored.
- Data bit count = 8·min(DLC,8); 0 when RTR=1. Zero data bits: DLC→CRC directly.
- Fields arrive MSB first. Each state advances on i_bit_valid only.
- CRC-15: poly 0x4599, init 0, over SOF through last data bit. Received 15 CRC bits compared against the computed value.
- DONE evaluation, in priority order:
  - mismatch → o_crc_err;
  - match & !i_fifo_full → o_crc_ok + o_fifo_wr_en;
  - match & i_fifo_full → o_crc_ok + o_overrun, no write.
- DONE then returns to IDLE.
- i_abort in any non-IDLE state → IDLE next cycle; no pulses, no write.
- i_sof while not IDLE → current frame dropped silently; restart at ID_A with this SOF bit.
- i_abort and i_sof in the same cycle → abort wins.
- o_fifo_w_data updates only with a write; it holds the last written word otherwise.

## Timing
- All outputs are registered.
- Reset value of every output is 0, including o_fifo_w_data.
- Reset mid-frame discards the frame; FSM returns to IDLE.
- Last CRC bit sampled at edge N → FSM in DONE after edge N. o_fifo_wr_en / o_crc_ok / o_crc_err / o_overrun high during cycle N+1 only, with o_fifo_w_data valid in that same cycle.
- i_fifo_full is sampled in the DONE cycle.
- o_busy rises the cycle after SOF is sampled. It falls the cycle after DONE or abort.
- Back-to-back frames: SOF may arrive the cycle right after DONE. Minimum gap between frames is one clock.
- Throughput: one bit per clock maximum.

## Configuration
- CAN_RX_TIMESTAMP_EN defined:
  - a TS_WIDTH-bit free-running counter, reset to 0, wrapping at all-ones;
  - its value is captured on the SOF-sampling edge;
  - the captured value is written to [98+TS_WIDTH:99].
- Undefined: no counter; [127:99] = 0.

## Test plan
- Standard ID 0x123, DLC 2, data AB CD, correct CRC → single o_fifo_wr_en with:
  - word[98:88]=0x123, [69]=0, [68]=0, [67:64]=2;
  - [63:48]=0xABCD, [47:0]=0;
  - o_crc_ok pulses in the same cycle.
- Extended ID 0x12345678 (IDA 0x48D, IDB 0x05678), DLC 8, data 01..08 → [98:70]=0x12345678, [69]=1, [63:0]=0x0102030405060708.
- Same standard frame with one CRC bit flipped → o_crc_err for one cycle; no o_fifo_wr_en, no o_crc_ok.
- i_fifo_full=1 during a good frame → o_crc_ok and o_overrun pulse, no write. Next frame with full=0 writes normally.
- i_abort during data byte 1, then a new standard RTR frame, DLC 4 → only the second frame is written: [68]=1, [67:64]=4, [63:0]=0.
- Timestamp (CAN_RX_TIMESTAMP_EN): SOF sampled when the counter = 0x00FF → word[114:99]=0x00FF. Without the macro, [127:99]=0.

Source files
------------

// File: rtl/can_rx_frame_packer.sv
// CAN receive frame assembler: parses destuffed standard/extended frames, checks CRC-15 and packs
// good frames into one 128-bit Rx FIFO word. Optional SOF timestamping via `CAN_RX_TIMESTAMP_EN.
module can_rx_frame_packer #(
  parameter int DATA_WIDTH = 128,
  parameter int TS_WIDTH   = 16
) (
  input  logic                  i_sys_clk,
  input  logic                  i_reset_n,
  input  logic                  i_sof,
  input  logic                  i_bit_valid,
  input  logic                  i_bit,
  input  logic                  i_abort,
  input  logic                  i_fifo_full,
  output logic [DATA_WIDTH-1:0] o_fifo_w_data,
  output logic                  o_fifo_wr_en,
  output logic                  o_crc_ok,
  output logic                  o_crc_err,
  output logic                  o_overrun,
  output logic                  o_busy
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_ID_A, ST_SRR_RTR, ST_IDE, ST_ID_B, ST_RTR_X,
    ST_R1, ST_R0, ST_DLC, ST_DATA, ST_CRC, ST_DONE
  } state_e;

  state_e                state_q;
  logic [5:0]            cnt_q;
  logic [14:0]           crc_q;
  logic [14:0]           crc_d;
  logic [14:0]           crc_rx_q;
  logic [10:0]           ida_q;
  logic [17:0]           idb_q;
  logic                  rtr_q;
  logic                  ide_q;
  logic [3:0]            dlc_q;
  logic [3:0]            dlc_d;
  logic [63:0]           data_q;
  logic [5:0]            data_last_q;
  logic [DATA_WIDTH-1:0] word_d;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic                  wr_en_q;
  logic                  crc_ok_q;
  logic                  crc_err_q;
  logic                  overrun_q;
  logic                  busy_q;

`ifdef CAN_RX_TIMESTAMP_EN
  logic [TS_WIDTH-1:0]   ts_q;
  logic [TS_WIDTH-1:0]   ts_cap_q;

  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) ts_q <= '0;
    else            ts_q <= ts_q + 1'b1;
  end
`endif

  function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
    logic fb;
    fb = b ^ c[14];
    crc_step = {c[13:0], 1'b0} ^ (fb ? 15'h4599 : 15'h0000);
  endfunction

  assign crc_d = crc_step(crc_q, i_bit);
  assign dlc_d = {dlc_q[2:0], i_bit};

  // Fields are cleared at SOF, so bytes beyond the DLC and IDB of standard frames stay zero.
  always_comb begin
    word_d         = '0;
    word_d[63:0]   = data_q;
    word_d[67:64]  = dlc_q;
    word_d[68]     = rtr_q;
    word_d[69]     = ide_q;
    word_d[98:88]  = ida_q;
    word_d[87:70]  = idb_q;
`ifdef CAN_RX_TIMESTAMP_EN
    word_d[98+TS_WIDTH:99] = ts_cap_q;
`else
    word_d[98+TS_WIDTH:99] = {TS_WIDTH{1'b0}};
`endif
  end

  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      crc_q       <= '0;
      crc_rx_q    <= '0;
      ida_q       <= '0;
      idb_q       <= '0;
      rtr_q       <= 1'b0;
      ide_q       <= 1'b0;
      dlc_q       <= '0;
      data_q      <= '0;
      data_last_q <= '0;
      w_data_q    <= '0;
      wr_en_q     <= 1'b0;
      crc_ok_q    <= 1'b0;
      crc_err_q   <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef CAN_RX_TIMESTAMP_EN
      ts_cap_q    <= '0;
`endif
    end else begin
      wr_en_q   <= 1'b0;
      crc_ok_q  <= 1'b0;
      crc_err_q <= 1'b0;
      overrun_q <= 1'b0;
      if (state_q != ST_IDLE && i_abort) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else if (i_sof && i_bit_valid && !i_abort) begin
        // A SOF always starts a fresh frame, silently dropping any frame in progress.
        state_q  <= ST_ID_A;
        cnt_q    <= '0;
        crc_q    <= crc_step(15'h0000, i_bit);
        crc_rx_q <= '0;
        ida_q    <= '0;
        idb_q    <= '0;
        rtr_q    <= 1'b0;
        ide_q    <= 1'b0;
        dlc_q    <= '0;
        data_q   <= '0;
        busy_q   <= 1'b1;
`ifdef CAN_RX_TIMESTAMP_EN
        ts_cap_q <= ts_q;
`endif
      end else if (state_q == ST_DONE) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
        if (crc_rx_q != crc_q) begin
          crc_err_q <= 1'b1;
        end else if (!i_fifo_full) begin
          crc_ok_q <= 1'b1;
          wr_en_q  <= 1'b1;
          w_data_q <= word_d;
        end else begin
          crc_ok_q  <= 1'b1;
          overrun_q <= 1'b1;
        end
      end else if (i_bit_valid) begin
        case (state_q)
          ST_ID_A: begin
            ida_q <= {ida_q[9:0], i_bit};
            crc_q <= crc_d;
            if (cnt_q == 6'd10) begin
              cnt_q   <= '0;
              state_q <= ST_SRR_RTR;
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
          ST_SRR_RTR: begin
            rtr_q   <= i_bit;
            crc_q   <= crc_d;
            state_q <= ST_IDE;
          end
          ST_IDE: begin
            ide_q   <= i_bit;
            crc_q   <= crc_d;
            cnt_q   <= '0;
            state_q <= i_bit ? ST_ID_B : ST_R0;
          end
          ST_ID_B: begin
            idb_q <= {idb_q[16:0], i_bit};
            crc_q <= crc_d;
            if (cnt_q == 6'd17) begin
              cnt_q   <= '0;
              state_q <= ST_RTR_X;
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
          ST_RTR_X: begin
            rtr_q   <= i_bit;
            crc_q   <= crc_d;
            state_q <= ST_R1;
          end
          ST_R1: begin
            crc_q   <= crc_d;
            state_q <= ST_R0;
          end
          ST_R0: begin
            crc_q   <= crc_d;
            cnt_q   <= '0;
            state_q <= ST_DLC;
          end
          ST_DLC: begin
            dlc_q <= dlc_d;
            crc_q <= crc_d;
            if (cnt_q == 6'd3) begin
              cnt_q       <= '0;
              data_last_q <= dlc_d[3] ? 6'd63 : {dlc_d[2:0] - 3'd1, 3'b111};
              state_q     <= (rtr_q || dlc_d == 4'd0) ? ST_CRC : ST_DATA;
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
          ST_DATA: begin
            data_q[6'd63 - cnt_q] <= i_bit;
            crc_q <= crc_d;
            if (cnt_q == data_last_q) begin
              cnt_q   <= '0;
              state_q <= ST_CRC;
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
          ST_CRC: begin
            crc_rx_q <= {crc_rx_q[13:0], i_bit};
            if (cnt_q == 6'd14) begin
              cnt_q   <= '0;
              state_q <= ST_DONE;
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_fifo_w_data = w_data_q;
  assign o_fifo_wr_en  = wr_en_q;
  assign o_crc_ok      = crc_ok_q;
  assign o_crc_err     = crc_err_q;
  assign o_overrun     = overrun_q;
  assign o_busy        = busy_q;

endmodule

// File: tb/tb_can_rx_frame_packer.sv
// Bench for can_rx_frame_packer: table of frames plus hand-written abort/restart/reset sequences,
// with a scoreboard queue matched against the output pulses.
module tb_can_rx_frame_packer;

  logic         clk = 1'b0;
  logic         rstN = 1'b0;
  logic         sof = 1'b0;
  logic         bitValid = 1'b0;
  logic         bitIn = 1'b1;
  logic         abort = 1'b0;
  logic         fifoFull = 1'b0;
  logic [127:0] wData;
  logic         wrEn;
  logic         crcOk;
  logic         crcErr;
  logic         overrun;
  logic         busy;

  can_rx_frame_packer dut (
    .i_sys_clk    (clk),
    .i_reset_n    (rstN),
    .i_sof        (sof),
    .i_bit_valid  (bitValid),
    .i_bit        (bitIn),
    .i_abort      (abort),
    .i_fifo_full  (fifoFull),
    .o_fifo_w_data(wData),
    .o_fifo_wr_en (wrEn),
    .o_crc_ok     (crcOk),
    .o_crc_err    (crcErr),
    .o_overrun    (overrun),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] tsModel;
  always @(posedge clk or negedge rstN) begin
    if (!rstN) tsModel <= 16'h0000;
    else       tsModel <= tsModel + 16'h0001;
  end

  typedef struct {
    logic        ide;
    logic [28:0] id;
    logic        rtr;
    logic [3:0]  dlc;
    logic [63:0] data;
    int          flipBit;
    logic        full;
    logic [3:0]  expFlags;
  } vec_t;

  typedef struct {
    logic [3:0]   flags;
    logic [127:0] word;
    int           cycle;
  } exp_t;

  int           nChecks = 0;
  int           nPassed = 0;
  exp_t         expQ[$];
  exp_t         monE;
  logic         frameBits[$];
  logic [127:0] lastWritten = '0;
  int           lastCyc;
  logic [15:0]  sofTs;
  vec_t         vecs[9];

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    nChecks++;
    if (actual === expected) nPassed++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
  endtask

  function automatic logic [14:0] crcModel(input logic [14:0] c, input logic b);
    logic [14:0] n;
    n = {c[13:0], 1'b0};
    if (b ^ c[14]) n = n ^ 15'h4599;
    return n;
  endfunction

  function automatic logic [127:0] makeWord(input logic ide, input logic [28:0] id, input logic rtr,
                                            input logic [3:0] dlc, input logic [63:0] data, input logic [15:0] ts);
    logic [127:0] w;
    int nb;
    w = '0;
    nb = rtr ? 0 : ((int'(dlc) > 8) ? 8 : int'(dlc));
    for (int i = 0; i < nb; i++) w[63-8*i -: 8] = data[63-8*i -: 8];
    w[67:64] = dlc;
    w[68]    = rtr;
    w[69]    = ide;
    w[98:70] = ide ? id : {id[10:0], 18'h0};
`ifdef CAN_RX_TIMESTAMP_EN
    w[114:99] = ts;
`else
    if (ts != ts) w = '1;
`endif
    return w;
  endfunction

  task automatic buildFrame(input logic ide, input logic [28:0] id, input logic rtr,
                            input logic [3:0] dlc, input logic [63:0] data, input int flipBit);
    logic [14:0] crc;
    int nb;
    frameBits.delete();
    frameBits.push_back(1'b0);
    for (int k = 10; k >= 0; k--) frameBits.push_back(ide ? id[18+k] : id[k]);
    if (ide) begin
      frameBits.push_back(1'b1);
      frameBits.push_back(1'b1);
      for (int k = 17; k >= 0; k--) frameBits.push_back(id[k]);
      frameBits.push_back(rtr);
      frameBits.push_back(1'b0);
      frameBits.push_back(1'b0);
    end else begin
      frameBits.push_back(rtr);
      frameBits.push_back(1'b0);
      frameBits.push_back(1'b0);
    end
    for (int k = 3; k >= 0; k--) frameBits.push_back(dlc[k]);
    nb = rtr ? 0 : ((int'(dlc) > 8) ? 64 : 8 * int'(dlc));
    for (int k = 0; k < nb; k++) frameBits.push_back(data[63-k]);
    crc = '0;
    foreach (frameBits[k]) crc = crcModel(crc, frameBits[k]);
    for (int k = 14; k >= 0; k--) frameBits.push_back(crc[k] ^ (flipBit == 14 - k));
  endtask

  // Drives frameBits one per clock (SOF on the first); stops before index stopAt when stopAt >= 0.
  task automatic applyStimulus(input int stopAt, input logic full);
    for (int i = 0; i < frameBits.size(); i++) begin
      if (i == stopAt) break;
      @(posedge clk); #1;
      if (i == 1) checkOutput("busy_after_sof", 128'(busy), 128'(1));
      sof      = (i == 0);
      bitValid = 1'b1;
      bitIn    = frameBits[i];
      if (i == 0) begin
        fifoFull = full;
        sofTs    = tsModel;
      end
      lastCyc = cyc;
    end
    @(posedge clk); #1;
    sof      = 1'b0;
    bitValid = 1'b0;
    bitIn    = 1'b1;
  endtask

  task automatic runVector(input vec_t v);
    exp_t e;
    buildFrame(v.ide, v.id, v.rtr, v.dlc, v.data, v.flipBit);
    applyStimulus(-1, v.full);
    e.flags = v.expFlags;
    e.word  = makeWord(v.ide, v.id, v.rtr, v.dlc, v.data, sofTs);
    e.cycle = lastCyc + 2;
    expQ.push_back(e);
  endtask

  // Every output pulse must match the oldest outstanding expectation, in value and in cycle.
  always @(negedge clk) begin
    if (rstN && (wrEn || crcOk || crcErr || overrun)) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_pulse", 128'({wrEn, crcOk, crcErr, overrun}), 128'(0));
      end else begin
        monE = expQ.pop_front();
        checkOutput("pulse_flags", 128'({wrEn, crcOk, crcErr, overrun}), 128'(monE.flags));
        checkOutput("pulse_cycle", 128'(cyc), 128'(monE.cycle));
        if (monE.flags[3]) begin
          checkOutput("fifo_word", wData, monE.word);
          lastWritten = monE.word;
        end else begin
          checkOutput("word_hold", wData, lastWritten);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b0, 29'h123,      1'b0, 4'd2,  64'hABCD_0000_0000_0000, -1, 1'b0, 4'b1100};
    vecs[1] = '{1'b1, 29'h12345678, 1'b0, 4'd8,  64'h0102_0304_0506_0708, -1, 1'b0, 4'b1100};
    vecs[2] = '{1'b0, 29'h123,      1'b0, 4'd2,  64'hABCD_0000_0000_0000,  7, 1'b0, 4'b0010};
    vecs[3] = '{1'b0, 29'h123,      1'b0, 4'd2,  64'hABCD_0000_0000_0000, -1, 1'b1, 4'b0101};
    vecs[4] = '{1'b0, 29'h2A5,      1'b0, 4'd1,  64'h5A00_0000_0000_0000, -1, 1'b0, 4'b1100};
    vecs[5] = '{1'b0, 29'h7FF,      1'b0, 4'd0,  64'hFFFF_FFFF_FFFF_FFFF, -1, 1'b0, 4'b1100};
    vecs[6] = '{1'b0, 29'h000,      1'b0, 4'd15, 64'hF0E1_D2C3_B4A5_9687, -1, 1'b0, 4'b1100};
    vecs[7] = '{1'b1, 29'h1FFFFFFF, 1'b1, 4'd3,  64'h1122_3344_5566_7788, -1, 1'b0, 4'b1100};
    vecs[8] = '{1'b1, 29'h0ABCDEF0, 1'b0, 4'd5,  64'hDEAD_BEEF_CA00_0000, 14, 1'b0, 4'b0010};

    $display("[TB] reset checks");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_w_data", wData, '0);
    checkOutput("reset_pulses", 128'({wrEn, crcOk, crcErr, overrun}), 128'(0));
    checkOutput("reset_busy", 128'(busy), 128'(0));
    rstN = 1'b1;

`ifdef CAN_RX_TIMESTAMP_EN
    for (int k = 0; k < 400 && tsModel != 16'h00FE; k++) begin
      @(posedge clk); #1;
    end
`endif

    $display("[TB] table vectors");
    for (int v = 0; v < 9; v++) runVector(vecs[v]);

    $display("[TB] abort during data byte 1, then standard RTR frame");
    buildFrame(1'b0, 29'h123, 1'b0, 4'd2, 64'hABCD_0000_0000_0000, -1);
    applyStimulus(30, 1'b0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checkOutput("busy_after_abort", 128'(busy), 128'(0));
    runVector('{1'b0, 29'h555, 1'b1, 4'd4, 64'h0, -1, 1'b0, 4'b1100});

    $display("[TB] SOF mid-frame restarts");
    buildFrame(1'b1, 29'h0000_0001, 1'b0, 4'd8, 64'h1, -1);
    applyStimulus(9, 1'b0);
    runVector('{1'b0, 29'h3C3, 1'b0, 4'd3, 64'h1234_5600_0000_0000, -1, 1'b0, 4'b1100});

    $display("[TB] abort and SOF together");
    buildFrame(1'b0, 29'h0F0, 1'b0, 4'd1, 64'h0, -1);
    applyStimulus(12, 1'b0);
    sof = 1'b1; abort = 1'b1; bitValid = 1'b1; bitIn = 1'b0;
    @(posedge clk); #1;
    sof = 1'b0; abort = 1'b0; bitValid = 1'b0; bitIn = 1'b1;
    checkOutput("busy_abort_wins", 128'(busy), 128'(0));
    @(posedge clk); #1;
    checkOutput("busy_stays_idle", 128'(busy), 128'(0));

    $display("[TB] reset mid-frame");
    buildFrame(1'b0, 29'h321, 1'b0, 4'd2, 64'h9999_0000_0000_0000, -1);
    applyStimulus(20, 1'b0);
    rstN = 1'b0;
    #2;
    checkOutput("midreset_w_data", wData, '0);
    checkOutput("midreset_busy", 128'(busy), 128'(0));
    @(posedge clk); #1;
    rstN = 1'b1;
    lastWritten = '0;
    runVector(vecs[1]);

    repeat (6) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", 128'(expQ.size()), 128'(0));

    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule
